// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;
  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
endpackage

// File: rtl/mdu_core_step.sv
// One radix-2 iteration: shift-add multiply (mode=0) or restoring shift-subtract divide (mode=1).
module mdu_core_step #(
  parameter int WIDTH = 32
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);
  logic [WIDTH:0] sum, shifted, diff;

  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    if (!mode) begin
      // multiplier bits retire from the bottom of lo as product bits enter the top
      hi_nxt = sum[WIDTH:1];
      lo_nxt = {sum[0], acc_lo[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      hi_nxt = diff[WIDTH-1:0];
      lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_nxt = shifted[WIDTH-1:0];
      lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; 33 edges from start to done.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_r;
  logic             sa, sb;
  logic [WIDTH-1:0] a_raw, acc_hi, acc_lo, opnd;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             done_r;
  logic [WIDTH-1:0] step_hi, step_lo;

  logic             sgn_a, sgn_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] q_fix, r_fix;

  mdu_core_step #(.WIDTH(WIDTH)) u_step (
    .mode   (op_r[1]),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .opnd   (opnd),
    .hi_nxt (step_hi),
    .lo_nxt (step_lo)
  );

  always_comb begin
    sgn_a    = ~op[0] & a[WIDTH-1];
    sgn_b    = ~op[0] & b[WIDTH-1];
    abs_a    = sgn_a ? -a : a;
    abs_b    = sgn_b ? -b : b;
    prod     = {acc_hi, acc_lo};
    prod_fix = (op_r == MDU_MULT && (sa ^ sb)) ? -prod : prod;
    // truncating division: quotient sign is sa^sb, remainder follows the dividend
    q_fix    = (op_r == MDU_DIV && (sa ^ sb)) ? -acc_lo : acc_lo;
    r_fix    = (op_r == MDU_DIV && sa) ? -acc_hi : acc_hi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op_r   <= MDU_MULT;
      sa     <= 1'b0;
      sb     <= 1'b0;
      a_raw  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_r   <= op;
            sa     <= sgn_a;
            sb     <= sgn_b;
            a_raw  <= a;
            acc_hi <= '0;
            acc_lo <= abs_a;
            opnd   <= abs_b;
            cnt    <= '0;
            state  <= ST_CALC;
          end else begin
            if (mthi) hi_r <= wdata;
            if (mtlo) lo_r <= wdata;
          end
        end
        ST_CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) state <= ST_FIX;
        end
        ST_FIX: begin
          if (!op_r[1]) begin
            {hi_r, lo_r} <= prod_fix;
          end else if (opnd == '0) begin
            hi_r <= a_raw;
            lo_r <= '1;
          end else begin
            hi_r <= r_fix;
            lo_r <= q_fix;
          end
          done_r <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;
endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter: latency, results, corner cases, handshake rules.
module tb_mdu_iter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        mthi, mtlo;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Launch at the next falling edge; returns just after the start edge.
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts rising edges until done is seen; busy must stay high before that.
  task automatic wait_done(output int edges, output bit busy_ok);
    edges = 0;
    busy_ok = 1'b1;
    while (edges < 60) begin
      @(negedge clk);
      edges++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({busy, done, hi, lo} !== 66'h0) begin
      n_bad++; $display("FAIL reset_hold: got %h expected 0", {busy, done, hi, lo});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, hi, lo} !== 66'h0) begin
      n_bad++; $display("FAIL reset_release: got %h expected 0", {busy, done, hi, lo});
    end
  endtask

  task automatic test_mul;
    int e; bit bok;
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(e, bok);
    n_cmp++;
    if (e !== 33) begin n_bad++; $display("FAIL multu_latency: got %0d expected 33", e); end
    n_cmp++;
    if (bok !== 1'b1) begin n_bad++; $display("FAIL multu_busy: got %0b expected 1", bok); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL multu_busy_done: got %0b expected 0", busy); end
    n_cmp++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      n_bad++; $display("FAIL multu_result: got %h expected fffffffe00000001", {hi, lo});
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL done_pulse: got %0b expected 0", done); end

    start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done(e, bok);
    n_cmp++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      n_bad++; $display("FAIL mult_neg: got %h expected ffffffffffffffeb", {hi, lo});
    end
  endtask

  task automatic test_div;
    int e; bit bok;
    start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(e, bok);
    n_cmp++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      n_bad++; $display("FAIL div_neg: got %h expected fffffffffffffffd", {hi, lo});
    end
    start_op(2'b11, 32'd7, 32'd0);
    wait_done(e, bok);
    n_cmp++;
    if (e !== 33) begin n_bad++; $display("FAIL divz_latency: got %0d expected 33", e); end
    n_cmp++;
    if ({hi, lo} !== 64'h0000_0007_FFFF_FFFF) begin
      n_bad++; $display("FAIL divu_zero: got %h expected 00000007ffffffff", {hi, lo});
    end
    start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(e, bok);
    n_cmp++;
    if ({hi, lo} !== 64'h0000_0000_8000_0000) begin
      n_bad++; $display("FAIL div_overflow: got %h expected 0000000080000000", {hi, lo});
    end
  endtask

  task automatic test_busy_ignore;
    int e; bit bok;
    start_op(2'b01, 32'd5, 32'd6);
    repeat (9) @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd99; b = 32'd3;
    mthi = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    wait_done(e, bok);
    n_cmp++;
    if (e !== 23) begin n_bad++; $display("FAIL ignore_latency: got %0d expected 23", e); end
    n_cmp++;
    if ({hi, lo} !== 64'd30) begin
      n_bad++; $display("FAIL ignore_result: got %h expected 000000000000001e", {hi, lo});
    end
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hABCD;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    n_cmp++;
    if ({hi, lo} !== 64'h0000_ABCD_0000_ABCD) begin
      n_bad++; $display("FAIL mthi_mtlo: got %h expected 0000abcd0000abcd", {hi, lo});
    end
  endtask

  task automatic test_async_reset;
    int e; bit bok;
    start_op(2'b11, 32'd100, 32'd7);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, hi, lo} !== 66'h0) begin
      n_bad++; $display("FAIL midop_reset: got %h expected 0", {busy, done, hi, lo});
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_op(2'b11, 32'd100, 32'd7);
    wait_done(e, bok);
    n_cmp++;
    if ({hi, lo} !== {32'd2, 32'd14}) begin
      n_bad++; $display("FAIL divu_after_reset: got %h expected 000000020000000e", {hi, lo});
    end
  endtask

  task automatic test_priority;
    int e; bit bok;
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3;
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5555;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    n_cmp++;
    if ({busy, hi, lo} !== {1'b1, 32'd2, 32'd14}) begin
      n_bad++; $display("FAIL start_priority: got %h expected 1000000020000000e", {busy, hi, lo});
    end
    wait_done(e, bok);
    n_cmp++;
    if ({hi, lo} !== 64'd6) begin
      n_bad++; $display("FAIL priority_result: got %h expected 0000000000000006", {hi, lo});
    end
  endtask

  task automatic test_back_to_back;
    int e; bit bok;
    start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done(e, bok);
    start = 1'b1; op = 2'b10; a = 32'hFFFF_FFF9; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept: got %0b expected 1", busy); end
    repeat (10) @(negedge clk);
    n_cmp++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      n_bad++; $display("FAIL b2b_hold: got %h expected ffffffffffffffeb", {hi, lo});
    end
    wait_done(e, bok);
    n_cmp++;
    if (e !== 23) begin n_bad++; $display("FAIL b2b_spacing: got %0d expected 23", e); end
    n_cmp++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      n_bad++; $display("FAIL b2b_result: got %h expected fffffffffffffffd", {hi, lo});
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_mul();
    test_div();
    test_busy_ignore();
    test_async_reset();
    test_priority();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
